subcarrier_map: RTL and testbench

//  Stage directly upstream of the IFFT modulator in the 802.11a TX chain.

---
 rtl/subcarrier_map.sv | 152 +++++++++++++++
 tb/tb_subcarrier_map.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subcarrier_map.sv
// 802.11a subcarrier mapper: buffers 48 data points per OFDM symbol in a ping-pong
// pair of banks and emits 64 IFFT bins in natural order with pilots and nulls inserted.
module subcarrier_map #(
  parameter int unsigned         IQ_W      = 16,
  parameter logic [IQ_W-1:0]     PILOT_AMP = IQ_W'(16'h2000)
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [2*IQ_W-1:0]   DAT_I,
  input  logic                CYC_I,
  input  logic                STB_I,
  input  logic                WE_I,
  output logic                ACK_O,
  output logic [2*IQ_W-1:0]   DAT_O,
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O,
  input  logic                ACK_I
);

  localparam int unsigned DW      = 2 * IQ_W;
  localparam int unsigned N_DATA  = 48;
  localparam int unsigned IDX_W   = 6;
  localparam logic [6:0]  LFSR_SEED = 7'h7F;

  logic [DW-1:0]    mem [2][N_DATA];
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wbank;
  logic             rbank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_bin;
  logic [6:0]       lfsr;

  logic             wr_last;
  logic             rd_last;
  logic             load;
  logic             pol_neg;
  logic             use_data;
  logic             is_pilot;
  logic             pilot_neg;
  logic [IDX_W-1:0] k_idx;
  logic [DW-1:0]    bin_val;

  assign ACK_O   = CYC_I & STB_I & WE_I & ~full[wbank];
  assign WE_O    = STB_O;
  assign wr_last = (wr_idx == IDX_W'(N_DATA - 1));
  assign rd_last = (rd_bin == 6'd63);
  assign pol_neg = lfsr[6] ^ lfsr[3];
  // A new bin may be loaded unless the current one is still waiting for ACK_I.
  assign load    = full[rbank] & ~(STB_O & ~ACK_I);

  // Inverse mapping: output bin -> data index k, pilot or null.
  always_comb begin
    use_data  = 1'b0;
    is_pilot  = 1'b0;
    pilot_neg = pol_neg;
    k_idx     = '0;
    bin_val   = '0;
    if (rd_bin >= 6'd1 && rd_bin <= 6'd6) begin
      use_data = 1'b1;
      k_idx    = rd_bin + 6'd23;
    end else if (rd_bin >= 6'd8 && rd_bin <= 6'd20) begin
      use_data = 1'b1;
      k_idx    = rd_bin + 6'd22;
    end else if (rd_bin >= 6'd22 && rd_bin <= 6'd26) begin
      use_data = 1'b1;
      k_idx    = rd_bin + 6'd21;
    end else if (rd_bin >= 6'd38 && rd_bin <= 6'd42) begin
      use_data = 1'b1;
      k_idx    = rd_bin - 6'd38;
    end else if (rd_bin >= 6'd44 && rd_bin <= 6'd56) begin
      use_data = 1'b1;
      k_idx    = rd_bin - 6'd39;
    end else if (rd_bin >= 6'd58) begin
      use_data = 1'b1;
      k_idx    = rd_bin - 6'd40;
    end else if (rd_bin == 6'd7 || rd_bin == 6'd21 || rd_bin == 6'd43 || rd_bin == 6'd57) begin
      is_pilot  = 1'b1;
      pilot_neg = pol_neg ^ (rd_bin == 6'd21);
    end
    if (use_data) begin
      bin_val = mem[rbank][k_idx];
    end else if (is_pilot) begin
      bin_val = {(pilot_neg ? -PILOT_AMP : PILOT_AMP), {IQ_W{1'b0}}};
    end
  end

  always_comb begin
    full_nxt = full;
    if (ACK_O && wr_last) full_nxt[wbank] = 1'b1;
    if (load && rd_last)  full_nxt[rbank] = 1'b0;
  end

  // Symbol storage; contents need no reset since full flags gate every read.
  always_ff @(posedge CLK_I) begin
    if (ACK_O) mem[wbank][wr_idx] <= DAT_I;
  end

  // Write side: a fall of CYC_I discards any partial symbol.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wbank  <= 1'b0;
      wr_idx <= '0;
      full   <= '0;
    end else begin
      full <= full_nxt;
      if (!CYC_I) begin
        wr_idx <= '0;
      end else if (ACK_O) begin
        if (wr_last) begin
          wr_idx <= '0;
          wbank  <= ~wbank;
        end else begin
          wr_idx <= wr_idx + 6'd1;
        end
      end
    end
  end

  // Read side and pilot polarity scrambler.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      DAT_O  <= '0;
      STB_O  <= 1'b0;
      CYC_O  <= 1'b0;
      rd_bin <= '0;
      rbank  <= 1'b0;
      lfsr   <= LFSR_SEED;
    end else begin
      if (load) begin
        DAT_O <= bin_val;
        STB_O <= 1'b1;
        CYC_O <= 1'b1;
        if (rd_last) begin
          rd_bin <= '0;
          rbank  <= ~rbank;
          lfsr   <= {lfsr[5:0], pol_neg};
        end else begin
          rd_bin <= rd_bin + 6'd1;
        end
      end else if (ACK_I) begin
        STB_O <= 1'b0;
      end
      if (!CYC_I && full == 2'b00 && !STB_O) begin
        CYC_O <= 1'b0;
        lfsr  <= LFSR_SEED;
      end
    end
  end

endmodule

// File: tb/tb_subcarrier_map.sv
// Directed bench for subcarrier_map: compares every emitted bin against a forward
// k->bin mapping model with a fixed pilot polarity table.
module tb_subcarrier_map;

  logic        CLK_I;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int in_cnt = 0;
  int rx_first = -1;
  int rx_last = -1;
  logic [31:0] rx_q[$];

  // polarity per symbol of a packet: bit set means pilots inverted
  logic [7:0] neg_tab = 8'b0111_0000;

  subcarrier_map dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cyc++;

  always @(negedge CLK_I) begin
    if (RST_I && STB_O && ACK_I) begin
      rx_q.push_back(DAT_O);
      if (rx_first < 0) rx_first = cyc;
      rx_last = cyc;
    end
    if (RST_I && ACK_O) in_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkword(input int sv, input int k);
    int v;
    logic [15:0] i_part;
    logic [15:0] q_part;
    v = sv * 64 + k;
    i_part = 16'(v);
    q_part = 16'(-v);
    return {i_part, q_part};
  endfunction

  function automatic int k2bin(input int k);
    int sc;
    if (k < 5)       sc = k - 26;
    else if (k < 18) sc = k - 25;
    else if (k < 24) sc = k - 24;
    else if (k < 30) sc = k - 23;
    else if (k < 43) sc = k - 22;
    else             sc = k - 21;
    return (sc + 64) % 64;
  endfunction

  function automatic logic [31:0] exp_word(input int sv, input int b, input logic neg);
    logic [15:0] amp;
    if (b == 7 || b == 21 || b == 43 || b == 57) begin
      amp = ((b == 21) ^ neg) ? 16'hE000 : 16'h2000;
      return {amp, 16'h0000};
    end
    for (int k = 0; k < 48; k++)
      if (k2bin(k) == b) return mkword(sv, k);
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_at(input int svbase, input int i);
    return exp_word(svbase + i / 64, i % 64, neg_tab[(i / 64) % 8]);
  endfunction

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic push_word(input logic [31:0] d);
    int t = 0;
    DAT_I = d;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    @(negedge CLK_I);
    while (!ACK_O && t < 2000) begin
      @(negedge CLK_I);
      t++;
    end
    if (!ACK_O) check("push timeout", 32'(ACK_O), 32'd1);
    @(posedge CLK_I);
    #1;
    STB_I = 1'b0;
    WE_I  = 1'b0;
  endtask

  task automatic push_sym(input int sv, input int n);
    for (int k = 0; k < n; k++) push_word(mkword(sv, k));
  endtask

  task automatic wait_rx(input int n, input string tag);
    int t = 0;
    while (rx_q.size() < n && t < 5000) begin
      @(negedge CLK_I);
      t++;
    end
    check(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (CYC_O && t < 2000) begin
      @(negedge CLK_I);
      t++;
    end
    check(tag, 32'(CYC_O), 32'd0);
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check_syms(input int svbase, input int nsym, input string tag);
    for (int i = 0; i < nsym * 64; i++)
      check($sformatf("%s s%0d b%0d", tag, i / 64, i % 64), rx_q[i], exp_at(svbase, i));
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_first = -1;
    rx_last = -1;
  endtask

  initial begin
    int in_base;
    int held;
    RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0; ACK_I = 1'b0;
    #12;
    check("rst dat", DAT_O, 32'h0);
    check("rst stb", 32'(STB_O), 32'd0);
    check("rst cyc", 32'(CYC_O), 32'd0);
    check("rst ack", 32'(ACK_O), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    @(posedge CLK_I);
    #1;

    // single symbol, latency and contents
    clear_rx();
    ACK_I = 1'b1;
    CYC_I = 1'b1;
    push_sym(0, 48);
    check("t1 lat0 stb", 32'(STB_O), 32'd0);
    @(posedge CLK_I);
    #1;
    check("t1 lat1 stb", 32'(STB_O), 32'd1);
    check("t1 lat1 we", 32'(WE_O), 32'd1);
    check("t1 lat1 cyc", 32'(CYC_O), 32'd1);
    check("t1 lat1 dat", DAT_O, 32'h0);
    wait_rx(64, "t1 count");
    CYC_I = 1'b0;
    check_syms(0, 1, "t1");
    check("t1 bin1", rx_q[1], 32'h0018_FFE8);
    check("t1 bin38", rx_q[38], 32'h0000_0000);
    check("t1 bin63", rx_q[63], 32'h0017_FFE9);
    check("t1 bin7", rx_q[7], 32'h2000_0000);
    check("t1 bin21", rx_q[21], 32'hE000_0000);
    wait_idle("t1 idle");

    // six back-to-back symbols, polarity sequence, gapless output
    clear_rx();
    CYC_I = 1'b1;
    for (int s = 0; s < 6; s++) push_sym(1 + s, 48);
    wait_rx(384, "t2 count");
    CYC_I = 1'b0;
    check_syms(1, 6, "t2");
    check("t2 s4 bin7", rx_q[4 * 64 + 7], 32'hE000_0000);
    check("t2 s4 bin21", rx_q[4 * 64 + 21], 32'h2000_0000);
    check("t2 contiguous", 32'(rx_last - rx_first + 1), 32'd384);
    wait_idle("t2 idle");

    // downstream stall mid-symbol
    clear_rx();
    in_base = in_cnt;
    CYC_I = 1'b1;
    ACK_I = 1'b1;
    fork
      begin
        for (int s = 0; s < 3; s++) push_sym(8 + s, 48);
      end
      begin
        wait_rx(20, "t3 pre");
        @(posedge CLK_I);
        #1;
        ACK_I = 1'b0;
        @(negedge CLK_I);
        held = rx_q.size();
        for (int c = 0; c < 100; c++) begin
          if (c % 25 == 0) begin
            check($sformatf("t3 hold dat c%0d", c), DAT_O, exp_at(8, held));
            check($sformatf("t3 hold stb c%0d", c), 32'(STB_O), 32'd1);
          end
          @(negedge CLK_I);
        end
        check("t3 inputs", 32'(in_cnt - in_base), 32'd96);
        check("t3 ack full", 32'(ACK_O), 32'd0);
        @(posedge CLK_I);
        #1;
        ACK_I = 1'b1;
      end
    join
    wait_rx(192, "t3 count");
    CYC_I = 1'b0;
    check_syms(8, 3, "t3");
    wait_idle("t3 idle");
    check("t3 total", 32'(rx_q.size()), 32'd192);

    // partial symbol discarded
    clear_rx();
    CYC_I = 1'b1;
    push_sym(11, 30);
    CYC_I = 1'b0;
    repeat (5) @(posedge CLK_I);
    #1;
    check("t4 none", 32'(rx_q.size()), 32'd0);
    check("t4 stb", 32'(STB_O), 32'd0);
    CYC_I = 1'b1;
    push_sym(12, 48);
    wait_rx(64, "t4 count");
    CYC_I = 1'b0;
    check_syms(12, 1, "t4");
    wait_idle("t4 idle");

    // asynchronous reset mid-drain
    clear_rx();
    CYC_I = 1'b1;
    push_sym(13, 48);
    push_sym(15, 48);
    wait_rx(10, "t5 pre");
    @(posedge CLK_I);
    #3;
    RST_I = 1'b0;
    #1;
    check("t5 rst dat", DAT_O, 32'h0);
    check("t5 rst stb", 32'(STB_O), 32'd0);
    check("t5 rst cyc", 32'(CYC_O), 32'd0);
    CYC_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    @(posedge CLK_I);
    #1;
    clear_rx();
    CYC_I = 1'b1;
    push_sym(14, 48);
    wait_rx(64, "t5 count");
    CYC_I = 1'b0;
    check_syms(14, 1, "t5");
    wait_idle("t5 idle");
    check("t5 total", 32'(rx_q.size()), 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
